// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle ARM control FSM.
package multicycle_ctrl_pkg;

  localparam int unsigned TMR_W  = 8;
  localparam int unsigned PC_S_W = 2;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC     = 4'd3,
    ST_WB       = 4'd4,
    ST_BX       = 4'd5,
    ST_BL_LR    = 4'd6,
    ST_BR_ADDR  = 4'd7,
    ST_BR_PC    = 4'd8,
    ST_MEM_ADDR = 4'd9,
    ST_MEM_WAIT = 4'd10,
    ST_MEM_WB   = 4'd11,
    ST_FAULT    = 4'd12
  } state_t;

  localparam logic [3:0] ALU_ADD    = 4'b0100;
  localparam logic [3:0] ALU_PASS_B = 4'b1000;

  localparam logic [PC_S_W-1:0] PC_S_INC = 2'd0;
  localparam logic [PC_S_W-1:0] PC_S_RM  = 2'd1;
  localparam logic [PC_S_W-1:0] PC_S_ALU = 2'd2;

  localparam logic [3:0]  IR_B_MATCH   = 4'b1010;
  localparam logic [3:0]  IR_BL_MATCH  = 4'b1011;
  localparam logic [23:0] IR_BX_MATCH  = 24'h12FFF1;
  localparam logic [1:0]  IR_MEM_MATCH = 2'b01;

  // Per-cycle datapath strobes; every field returns to 0 unless the state drives it.
  typedef struct packed {
    logic              write_pc;
    logic              write_ir;
    logic              write_reg;
    logic              la;
    logic              lb;
    logic              lc;
    logic              lf;
    logic              lmdr;
    logic [PC_S_W-1:0] pc_s;
    logic              alu_a_s;
    logic              alu_b_s;
    logic              rd_s;
    logic              mem_req;
    logic              mem_we;
    logic              wb_mdr;
  } strobe_t;

  // How the held decoder copies are updated on entering a state.
  typedef enum logic [2:0] {
    CL_HOLD    = 3'd0,
    CL_DEC     = 3'd1,
    CL_PASS_B  = 3'd2,
    CL_BR_ADD  = 3'd3,
    CL_MEM_ADD = 3'd4
  } ctrl_ld_t;

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Cycle counter for MEM_WAIT: cleared on address phase, counts wait cycles, flags the limit.
module mem_wait_timer
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TMO = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic done_c
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + TMR_W'(1);
    end
  end

  assign done_c = (count == TMR_W'(MEM_TMO));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle ARM control FSM: fetch/decode/execute for DP, B/BL/BX and LDR/STR.
// Outputs are registered from the next-state decode so they line up with the state they belong to.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W   = 4,
  parameter int unsigned SHIFT_OP_W = 3,
  parameter int unsigned MEM_TMO    = 15,
  parameter bit          HAS_MEM    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           ir,
  input  logic                  ir_valid,
  input  logic                  cond_pass,
  input  logic                  rm_imm_s,
  input  logic [1:0]            rs_imm_s,
  input  logic [SHIFT_OP_W-1:0] shift_op,
  input  logic [ALU_OP_W-1:0]   alu_op,
  input  logic                  s_bit,
  input  logic                  ttcc,
  input  logic                  mem_ack,
  output logic                  write_pc,
  output logic                  write_ir,
  output logic                  write_reg,
  output logic                  la,
  output logic                  lb,
  output logic                  lc,
  output logic                  lf,
  output logic                  lmdr,
  output logic [PC_S_W-1:0]     pc_s,
  output logic                  alu_a_s,
  output logic                  alu_b_s,
  output logic                  rd_s,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  wb_mdr,
  output logic                  s_ctrl,
  output logic                  rm_imm_s_ctrl,
  output logic [1:0]            rs_imm_s_ctrl,
  output logic [SHIFT_OP_W-1:0] shift_op_ctrl,
  output logic [ALU_OP_W-1:0]   alu_op_ctrl,
  output logic                  fault
);

  state_t   st;
  state_t   next_st;
  strobe_t  strb_d;
  strobe_t  strb_q;
  ctrl_ld_t ctrl_ld;

  logic is_b;
  logic is_bl;
  logic is_bx;
  logic is_mem;
  logic is_load;
  logic tmr_clr;
  logic tmr_inc;
  logic tmr_done;
  logic unused_ir;

  // Instruction-class decode
  always_comb begin
    is_b    = (ir[27:24] == IR_B_MATCH);
    is_bl   = (ir[27:24] == IR_BL_MATCH);
    is_bx   = (ir[27:4] == IR_BX_MATCH);
    is_mem  = (ir[27:26] == IR_MEM_MATCH);
    is_load = ir[20];
  end

  // Condition field and Rm are consumed elsewhere (cond_pass / regfile).
  assign unused_ir = ^{ir[31:28], ir[3:0]};

  assign tmr_clr = (st == ST_MEM_ADDR);
  assign tmr_inc = (st == ST_MEM_WAIT);

  mem_wait_timer #(
    .MEM_TMO (MEM_TMO)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .done_c (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= ST_IDLE;
    end else begin
      st <= next_st;
    end
  end

  // Next state plus the strobe/load decode of that next state
  always_comb begin
    next_st = ST_FETCH;
    strb_d  = '0;
    ctrl_ld = CL_HOLD;

    case (st)
      ST_IDLE:     next_st = ST_FETCH;
      ST_FETCH:    next_st = ir_valid ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (!cond_pass)  next_st = ST_FETCH;
        else if (is_b)   next_st = ST_BR_ADDR;
        else if (is_bl)  next_st = ST_BL_LR;
        else if (is_bx)  next_st = ST_BX;
        else if (is_mem) next_st = HAS_MEM ? ST_MEM_ADDR : ST_FAULT;
        else             next_st = ST_EXEC;
      end
      ST_EXEC:     next_st = ttcc ? ST_FETCH : ST_WB;
      ST_WB:       next_st = ST_FETCH;
      ST_BX:       next_st = ST_FETCH;
      ST_BL_LR:    next_st = ST_BR_ADDR;
      ST_BR_ADDR:  next_st = ST_BR_PC;
      ST_BR_PC:    next_st = ST_FETCH;
      ST_MEM_ADDR: next_st = ST_MEM_WAIT;
      // ack takes priority over the timeout on the same cycle
      ST_MEM_WAIT: begin
        if (mem_ack)       next_st = is_load ? ST_MEM_WB : ST_FETCH;
        else if (tmr_done) next_st = ST_FAULT;
        else               next_st = ST_MEM_WAIT;
      end
      ST_MEM_WB:   next_st = ST_FETCH;
      ST_FAULT:    next_st = ST_FAULT;
      default:     next_st = ST_FETCH;
    endcase

    case (next_st)
      ST_FETCH: begin
        strb_d.write_pc = 1'b1;
        strb_d.write_ir = 1'b1;
        strb_d.pc_s     = PC_S_INC;
      end
      ST_DECODE: begin
        strb_d.la = 1'b1;
        strb_d.lb = 1'b1;
        strb_d.lc = 1'b1;
      end
      ST_EXEC: begin
        strb_d.lf = 1'b1;
        ctrl_ld   = CL_DEC;
      end
      ST_WB:       strb_d.write_reg = 1'b1;
      ST_BX: begin
        strb_d.write_pc = 1'b1;
        strb_d.pc_s     = PC_S_RM;
      end
      ST_BL_LR: begin
        strb_d.alu_a_s   = 1'b1;
        strb_d.rd_s      = 1'b1;
        strb_d.write_reg = 1'b1;
        ctrl_ld          = CL_PASS_B;
      end
      ST_BR_ADDR: begin
        strb_d.alu_a_s = 1'b1;
        strb_d.alu_b_s = 1'b1;
        strb_d.lc      = 1'b1;
        ctrl_ld        = CL_BR_ADD;
      end
      ST_BR_PC: begin
        strb_d.write_pc = 1'b1;
        strb_d.pc_s     = PC_S_ALU;
      end
      ST_MEM_ADDR: begin
        strb_d.alu_b_s = 1'b1;
        strb_d.lc      = 1'b1;
        ctrl_ld        = CL_MEM_ADD;
      end
      ST_MEM_WAIT: begin
        strb_d.mem_req = 1'b1;
        strb_d.mem_we  = !is_load;
      end
      ST_MEM_WB: begin
        strb_d.lmdr      = 1'b1;
        strb_d.wb_mdr    = 1'b1;
        strb_d.write_reg = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs; decoder copies hold between loads, fault is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_q        <= '0;
      fault         <= 1'b0;
      s_ctrl        <= 1'b0;
      rm_imm_s_ctrl <= 1'b0;
      rs_imm_s_ctrl <= '0;
      shift_op_ctrl <= '0;
      alu_op_ctrl   <= '0;
    end else begin
      strb_q <= strb_d;
      fault  <= fault | (next_st == ST_FAULT);
      case (ctrl_ld)
        CL_DEC: begin
          s_ctrl        <= s_bit;
          rm_imm_s_ctrl <= rm_imm_s;
          rs_imm_s_ctrl <= rs_imm_s;
          shift_op_ctrl <= shift_op;
          alu_op_ctrl   <= alu_op;
        end
        CL_PASS_B: begin
          s_ctrl      <= 1'b0;
          alu_op_ctrl <= ALU_OP_W'(ALU_PASS_B);
        end
        CL_BR_ADD: begin
          s_ctrl      <= 1'b0;
          alu_op_ctrl <= ALU_OP_W'(ALU_ADD);
        end
        CL_MEM_ADD: alu_op_ctrl <= ALU_OP_W'(ALU_ADD);
        default: ;
      endcase
    end
  end

  assign write_pc  = strb_q.write_pc;
  assign write_ir  = strb_q.write_ir;
  assign write_reg = strb_q.write_reg;
  assign la        = strb_q.la;
  assign lb        = strb_q.lb;
  assign lc        = strb_q.lc;
  assign lf        = strb_q.lf;
  assign lmdr      = strb_q.lmdr;
  assign pc_s      = strb_q.pc_s;
  assign alu_a_s   = strb_q.alu_a_s;
  assign alu_b_s   = strb_q.alu_b_s;
  assign rd_s      = strb_q.rd_s;
  assign mem_req   = strb_q.mem_req;
  assign mem_we    = strb_q.mem_we;
  assign wb_mdr    = strb_q.wb_mdr;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-state strobe vectors and held decoder copies.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir;
  logic        ir_valid;
  logic        cond_pass;
  logic        rm_imm_s;
  logic [1:0]  rs_imm_s;
  logic [2:0]  shift_op;
  logic [3:0]  alu_op;
  logic        s_bit;
  logic        ttcc;
  logic        mem_ack;
  logic        write_pc, write_ir, write_reg, la, lb, lc, lf, lmdr;
  logic [1:0]  pc_s;
  logic        alu_a_s, alu_b_s, rd_s, mem_req, mem_we, wb_mdr;
  logic        s_ctrl, rm_imm_s_ctrl;
  logic [1:0]  rs_imm_s_ctrl;
  logic [2:0]  shift_op_ctrl;
  logic [3:0]  alu_op_ctrl;
  logic        fault;

  int passed = 0;
  int total  = 0;

  // Strobe vector bit masks
  localparam logic [16:0] B_WPC  = 17'h10000;
  localparam logic [16:0] B_WIR  = 17'h08000;
  localparam logic [16:0] B_WREG = 17'h04000;
  localparam logic [16:0] B_LA   = 17'h02000;
  localparam logic [16:0] B_LB   = 17'h01000;
  localparam logic [16:0] B_LC   = 17'h00800;
  localparam logic [16:0] B_LF   = 17'h00400;
  localparam logic [16:0] B_LMDR = 17'h00200;
  localparam logic [16:0] B_PC2  = 17'h00100;
  localparam logic [16:0] B_PC1  = 17'h00080;
  localparam logic [16:0] B_AAS  = 17'h00040;
  localparam logic [16:0] B_ABS  = 17'h00020;
  localparam logic [16:0] B_RDS  = 17'h00010;
  localparam logic [16:0] B_MREQ = 17'h00008;
  localparam logic [16:0] B_MWE  = 17'h00004;
  localparam logic [16:0] B_WBM  = 17'h00002;
  localparam logic [16:0] B_FLT  = 17'h00001;

  localparam logic [16:0] E_ZERO   = 17'h0;
  localparam logic [16:0] E_FETCH  = B_WPC | B_WIR;
  localparam logic [16:0] E_DECODE = B_LA | B_LB | B_LC;
  localparam logic [16:0] E_EXEC   = B_LF;
  localparam logic [16:0] E_WB     = B_WREG;
  localparam logic [16:0] E_BX     = B_WPC | B_PC1;
  localparam logic [16:0] E_BLLR   = B_AAS | B_RDS | B_WREG;
  localparam logic [16:0] E_BRADDR = B_AAS | B_ABS | B_LC;
  localparam logic [16:0] E_BRPC   = B_WPC | B_PC2;
  localparam logic [16:0] E_MADDR  = B_ABS | B_LC;
  localparam logic [16:0] E_MW_LD  = B_MREQ;
  localparam logic [16:0] E_MW_ST  = B_MREQ | B_MWE;
  localparam logic [16:0] E_MWB    = B_LMDR | B_WBM | B_WREG;
  localparam logic [16:0] E_FAULT  = B_FLT;

  logic [16:0] obs_s;
  logic [10:0] obs_c;
  assign obs_s = {write_pc, write_ir, write_reg, la, lb, lc, lf, lmdr, pc_s,
                  alu_a_s, alu_b_s, rd_s, mem_req, mem_we, wb_mdr, fault};
  assign obs_c = {s_ctrl, rm_imm_s_ctrl, rs_imm_s_ctrl, shift_op_ctrl, alu_op_ctrl};

  multicycle_ctrl #(
    .ALU_OP_W   (4),
    .SHIFT_OP_W (3),
    .MEM_TMO    (4),
    .HAS_MEM    (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .cond_pass     (cond_pass),
    .rm_imm_s      (rm_imm_s),
    .rs_imm_s      (rs_imm_s),
    .shift_op      (shift_op),
    .alu_op        (alu_op),
    .s_bit         (s_bit),
    .ttcc          (ttcc),
    .mem_ack       (mem_ack),
    .write_pc      (write_pc),
    .write_ir      (write_ir),
    .write_reg     (write_reg),
    .la            (la),
    .lb            (lb),
    .lc            (lc),
    .lf            (lf),
    .lmdr          (lmdr),
    .pc_s          (pc_s),
    .alu_a_s       (alu_a_s),
    .alu_b_s       (alu_b_s),
    .rd_s          (rd_s),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .wb_mdr        (wb_mdr),
    .s_ctrl        (s_ctrl),
    .rm_imm_s_ctrl (rm_imm_s_ctrl),
    .rs_imm_s_ctrl (rs_imm_s_ctrl),
    .shift_op_ctrl (shift_op_ctrl),
    .alu_op_ctrl   (alu_op_ctrl),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_s(input string tag, input logic [16:0] exp);
    total = total + 1;
    assert (obs_s === exp) passed = passed + 1;
    else $error("FAIL %s strobes observed=%05h expected=%05h", tag, obs_s, exp);
  endtask

  task automatic chk_c(input string tag, input logic [10:0] exp);
    total = total + 1;
    assert (obs_c === exp) passed = passed + 1;
    else $error("FAIL %s ctrl observed=%03h expected=%03h", tag, obs_c, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    ir        = 32'h0;
    ir_valid  = 1'b0;
    cond_pass = 1'b1;
    rm_imm_s  = 1'b0;
    rs_imm_s  = 2'b00;
    shift_op  = 3'b000;
    alu_op    = 4'b0000;
    s_bit     = 1'b0;
    ttcc      = 1'b0;
    mem_ack   = 1'b0;

    // Reset state
    @(negedge clk);
    chk_s("reset_strobes", E_ZERO);
    chk_c("reset_ctrl", 11'h000);
    rst_n = 1'b1;

    // IDLE -> FETCH; ir_valid low keeps re-fetching
    step(); chk_s("fetch_first", E_FETCH);
    step(); chk_s("fetch_hold", E_FETCH);

    // ADD: FETCH, DECODE, EXEC, WB
    ir = 32'hE0810002; ir_valid = 1'b1; ttcc = 1'b0;
    s_bit = 1'b1; rm_imm_s = 1'b1; rs_imm_s = 2'b10; shift_op = 3'b010; alu_op = 4'b0100;
    step(); chk_s("add_decode", E_DECODE);
    step(); chk_s("add_exec", E_EXEC);
    chk_c("add_ctrl_load", 11'b1_1_10_010_0100);
    alu_op = 4'b1111; s_bit = 1'b0;
    step(); chk_s("add_wb", E_WB);
    step(); chk_s("add_back_fetch", E_FETCH);
    chk_c("add_ctrl_hold", 11'b1_1_10_010_0100);

    // CMP: no writeback, 3 cycles
    ir = 32'hE1510002; ttcc = 1'b1;
    s_bit = 1'b1; rm_imm_s = 1'b0; rs_imm_s = 2'b00; shift_op = 3'b000; alu_op = 4'b0010;
    step(); chk_s("cmp_decode", E_DECODE);
    step(); chk_s("cmp_exec", E_EXEC);
    chk_c("cmp_ctrl_load", 11'b1_0_00_000_0010);
    step(); chk_s("cmp_back_fetch", E_FETCH);

    // BL: LR write, branch add, PC load; decoder inputs must not leak in
    ir = 32'hEB000004; ttcc = 1'b0; s_bit = 1'b1; alu_op = 4'b1111;
    step(); chk_s("bl_decode", E_DECODE);
    step(); chk_s("bl_lr", E_BLLR);
    chk_c("bl_lr_ctrl", 11'b0_0_00_000_1000);
    step(); chk_s("bl_br_addr", E_BRADDR);
    chk_c("bl_br_addr_ctrl", 11'b0_0_00_000_0100);
    step(); chk_s("bl_br_pc", E_BRPC);
    step(); chk_s("bl_back_fetch", E_FETCH);

    // BX
    ir = 32'hE12FFF1E;
    step(); chk_s("bx_decode", E_DECODE);
    step(); chk_s("bx_pc", E_BX);
    step(); chk_s("bx_back_fetch", E_FETCH);

    // Condition fail on DP: DECODE straight back to FETCH
    ir = 32'hE0810002; cond_pass = 1'b0;
    step(); chk_s("skip_decode", E_DECODE);
    step(); chk_s("skip_fetch", E_FETCH);
    cond_pass = 1'b1;

    // LDR, ack on 4th wait cycle
    ir = 32'hE5910000;
    step(); chk_s("ldr_decode", E_DECODE);
    step(); chk_s("ldr_addr", E_MADDR);
    total = total + 1;
    assert (alu_op_ctrl === 4'b0100) passed = passed + 1;
    else $error("FAIL ldr_addr_aluop observed=%h expected=4", alu_op_ctrl);
    for (int i = 0; i < 4; i++) begin
      step(); chk_s("ldr_wait", E_MW_LD);
    end
    mem_ack = 1'b1;
    step(); chk_s("ldr_mem_wb", E_MWB);
    mem_ack = 1'b0;
    step(); chk_s("ldr_back_fetch", E_FETCH);

    // LDR, ack on the timeout cycle itself: ack wins
    step(); chk_s("ldr2_decode", E_DECODE);
    step(); chk_s("ldr2_addr", E_MADDR);
    for (int i = 0; i < 5; i++) begin
      step(); chk_s("ldr2_wait", E_MW_LD);
    end
    mem_ack = 1'b1;
    step(); chk_s("ldr2_ack_at_limit", E_MWB);
    mem_ack = 1'b0;
    step(); chk_s("ldr2_back_fetch", E_FETCH);

    // STR, no ack: 5 wait cycles then sticky FAULT
    ir = 32'hE5810000;
    step(); chk_s("str_decode", E_DECODE);
    step(); chk_s("str_addr", E_MADDR);
    for (int i = 0; i < 5; i++) begin
      step(); chk_s("str_wait", E_MW_ST);
    end
    step(); chk_s("str_fault", E_FAULT);
    mem_ack = 1'b1;
    step(); chk_s("fault_sticky1", E_FAULT);
    mem_ack = 1'b0;
    step(); chk_s("fault_sticky2", E_FAULT);

    // Asynchronous reset clears fault
    rst_n = 1'b0;
    #1;
    chk_s("fault_reset", E_ZERO);
    chk_c("fault_reset_ctrl", 11'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-MEM_WAIT drops everything without a clock edge
    step(); chk_s("rst2_fetch", E_FETCH);
    step(); chk_s("rst2_decode", E_DECODE);
    step(); chk_s("rst2_addr", E_MADDR);
    step(); chk_s("rst2_wait", E_MW_ST);
    #2;
    rst_n = 1'b0;
    #1;
    chk_s("rst_mid_wait", E_ZERO);
    chk_c("rst_mid_wait_ctrl", 11'h000);
    @(negedge clk);
    rst_n = 1'b1;
    step(); chk_s("rst2_refetch", E_FETCH);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
